clk_div_multi: RTL

Multi-channel successor to the single prescaler + divide-by-M clock divider. A shared power-of-two prescaler produces a tick stream. P_CH independent integer dividers count those ticks, and each channel drives a one-cycle enable pulse and a 50%-duty divided clock. New divide and prescale settings are loaded through shadow registers and applied only at period boundaries, so reconfiguration never produces runt pulses. The block sits between the system clock and downstream clock-enable consumers.

---
 rtl/clk_div_multi.sv | 134 +++++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: shared power-of-two prescaler feeding P_CH integer dividers.
// Each channel produces a one-cycle enable pulse and a 50%-duty divided clock.
// New settings go into shadow registers. They are applied only at period
// boundaries, so a running channel always finishes its current period.
// cfg_load is a plain one-cycle strobe with no handshake: every cycle it is
// high overwrites the shadows, and the last write before an apply point wins.
module clk_div_multi #(
  parameter int P_CH       = 4,
  parameter int P_PRE_BITS = 2,
  parameter int P_DIV_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_load,
  input  logic                         en_pre,
  input  logic [P_PRE_BITS-1:0]        pre_sel,
  input  logic [P_CH*P_DIV_BITS-1:0]   div_m,
  output logic                         pre_tick_o,
  output logic [P_CH-1:0]              clk_gate_o,
  output logic [P_CH-1:0]              clk_div_o,
  output logic                         cfg_pend_o
);

  // The largest exponent is 2^P_PRE_BITS-1, so the counter needs that many bits.
  localparam int PRE_CNT_W = (1 << P_PRE_BITS) - 1;
  localparam logic [PRE_CNT_W-1:0]  PRE_ONE  = PRE_CNT_W'(1);
  localparam logic [P_DIV_BITS-1:0] DIV_ONE  = P_DIV_BITS'(1);
  localparam logic [P_DIV_BITS-1:0] DIV_ZERO = '0;

  // Prescaler: active settings, shadow settings and pending flag
  logic                  act_en_pre;
  logic [P_PRE_BITS-1:0] act_pre_sel;
  logic [PRE_CNT_W-1:0]  pre_cnt;
  logic                  sh_en_pre;
  logic [P_PRE_BITS-1:0] sh_pre_sel;
  logic                  pend_pre;

  // Channels: active divide value, counter, shadow value and pending flag
  logic [P_DIV_BITS-1:0] act_div [P_CH];
  logic [P_DIV_BITS-1:0] cnt     [P_CH];
  logic [P_DIV_BITS-1:0] sh_div  [P_CH];
  logic [P_CH-1:0]       pend_ch;

  logic [PRE_CNT_W:0]    pre_pow;
  logic [PRE_CNT_W-1:0]  pre_limit;
  logic                  tick;
  logic [P_CH-1:0]       terminal;
  logic [P_CH-1:0]       apply;

  // The tick fires when the prescaler reaches 2^sel-1. A disabled prescaler
  // ticks on every cycle, and that includes the time before the first load.
  assign pre_pow   = (PRE_CNT_W+1)'(1) << act_pre_sel;
  assign pre_limit = pre_pow[PRE_CNT_W-1:0] - PRE_ONE;
  assign tick      = !act_en_pre || (pre_cnt == pre_limit);

  assign cfg_pend_o = pend_pre | (|pend_ch);

  // A channel boundary is its terminal tick. An idle channel (D=0) can accept
  // a new value on any tick.
  always_comb begin
    terminal = '0;
    apply    = '0;
    for (int i = 0; i < P_CH; i++) begin
      terminal[i] = tick && (act_div[i] != DIV_ZERO) && (cnt[i] == act_div[i] - DIV_ONE);
      apply[i]    = tick && (terminal[i] || (act_div[i] == DIV_ZERO));
    end
  end

  // Prescaler counter, its shadow capture and its apply on tick.
  // A load on the same edge as an apply lands in the shadow for the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_en_pre  <= 1'b0;
      act_pre_sel <= '0;
      pre_cnt     <= '0;
      sh_en_pre   <= 1'b0;
      sh_pre_sel  <= '0;
      pend_pre    <= 1'b0;
      pre_tick_o  <= 1'b0;
    end else begin
      pre_tick_o <= tick;
      if (tick) begin
        pre_cnt <= '0;
      end else if (act_en_pre) begin
        pre_cnt <= pre_cnt + PRE_ONE;
      end
      if (tick && pend_pre) begin
        act_en_pre  <= sh_en_pre;
        act_pre_sel <= sh_pre_sel;
        pend_pre    <= 1'b0;
      end
      if (cfg_load) begin
        sh_en_pre  <= en_pre;
        sh_pre_sel <= pre_sel;
        pend_pre   <= 1'b1;
      end
    end
  end

  // Per-channel counters, outputs and shadow/apply handling.
  // The divided clock is forced low whenever the channel's active D is zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < P_CH; i++) begin
        act_div[i] <= '0;
        cnt[i]     <= '0;
        sh_div[i]  <= '0;
      end
      pend_ch    <= '0;
      clk_gate_o <= '0;
      clk_div_o  <= '0;
    end else begin
      clk_gate_o <= terminal;
      for (int i = 0; i < P_CH; i++) begin
        if (apply[i] && pend_ch[i]) begin
          act_div[i]   <= sh_div[i];
          cnt[i]       <= '0;
          pend_ch[i]   <= 1'b0;
          clk_div_o[i] <= (sh_div[i] == DIV_ZERO) ? 1'b0 : (clk_div_o[i] ^ terminal[i]);
        end else begin
          if (tick && (act_div[i] != DIV_ZERO)) begin
            cnt[i] <= terminal[i] ? DIV_ZERO : cnt[i] + DIV_ONE;
          end
          clk_div_o[i] <= (act_div[i] == DIV_ZERO) ? 1'b0 : (clk_div_o[i] ^ terminal[i]);
        end
        if (cfg_load) begin
          sh_div[i]  <= div_m[i*P_DIV_BITS +: P_DIV_BITS];
          pend_ch[i] <= 1'b1;
        end
      end
    end
  end

endmodule
